pht_access_ctrl: RTL and testbench
==================================

Name: pht_access_ctrl

Overview:
- Controller for the 2-bit-counter pattern history table (PHT), held in an external single-port, synchronous-read RAM.
- Shares the single RAM port between fetch-stage lookups and EX-stage resolved-branch updates. Each update is a read-modify-write.
- Queues updates and sequences post-reset table initialisation.
- Sits between IF (lookup), EX (resolution) and the PHT RAM macro.

Parameters:
IDX_W, 8, PHT index width; index = pc[IDX_W+1:2]; table depth 2**IDX_W
Q_DEPTH, 4, update queue entries (power of 2, >=2)
INIT_VAL, 2'b01, counter value written at init (weak not-taken)
STARVE_LIM, 8, consecutive lost arbitrations before an update forces the port

Ports:
clk  in  1  clock
reset_n  in  1  asynchronous, active-low reset
lookup_valid  in  1  IF requests prediction for lookup_pc
lookup_pc  in  32  fetch PC
lookup_stall  out  1  lookup not accepted this cycle; IF must hold request
predict_valid  out  1  prediction valid (1 cycle after accepted lookup)
predict_taken  out  1  predicted direction (counter bit 1)
upd_valid  in  1  resolved branch outcome available
upd_pc  in  32  PC of resolved branch
upd_taken  in  1  actual direction
upd_ready  out  1  queue can accept; transfer on upd_valid&upd_ready
init_busy  out  1  table initialisation in progress
ram_en  out  1  RAM port enable
ram_we  out  1  RAM write enable
ram_addr  out  IDX_W  RAM address
ram_wdata  out  2  RAM write data
ram_rdata  in  2  RAM read data, valid the cycle after ram_en&!ram_we

Behaviour:
- Reset (reset_n low, async):
  - State = INIT, init address = 0.
  - Queue emptied, starvation counter = 0, no write pending.
  - predict_valid=0, predict_taken=0, lookup_stall=1, upd_ready=0, init_busy=1, ram_en=0.
- INIT:
  - One write per cycle: ram_en=1, ram_we=1, ram_addr=init addr, ram_wdata=INIT_VAL.
  - After writing address 2**IDX_W-1, go to RUN next cycle and drop init_busy. Init lasts exactly 2**IDX_W cycles.
  - Lookups are stalled and upd_ready=0 throughout.
  - Reset mid-init restarts at address 0.
- RUN port arbitration, evaluated each cycle:
  - Update engine "has work" when a write is pending or the queue is non-empty.
  - Priority order:
    1. Starvation counter == STARVE_LIM and engine has work: engine takes the port, and lookup_stall=1 if lookup_valid.
    2. lookup_valid: lookup takes the port, lookup_stall=0.
    3. Otherwise the engine takes the port.
  - Starvation counter: increments (saturating) when the engine has work and a lookup wins; clears whenever the engine takes the port.
- Lookup:
  - Grant at cycle t: ram_en=1, ram_we=0, ram_addr=lookup_pc[IDX_W+1:2].
  - At t+1: predict_valid=1, predict_taken=ram_rdata[1].
  - Forwarding: if a write is pending to the same index at t, predict_taken=pending value bit 1 instead.
  - predict_valid=0 in any cycle not following a grant.
- Update engine:
  - Port grant with no pending write: pop queue head, issue a read of its index.
  - Next cycle: compute the new counter from ram_rdata, saturating at 2'b11 on taken and 2'b00 on not-taken. Store index and value as the pending write.
  - Port grant with a pending write: ram_we=1, write it, clear pending.
  - At most one pending write. No pop while a write is pending, so back-to-back updates to the same index are serialised correctly.
  - A write may be deferred any number of cycles by lookups, bounded by STARVE_LIM.
- Queue:
  - FIFO with wrap-around pointers and an occupancy count.
  - upd_ready = !init_busy && count<Q_DEPTH.
  - Simultaneous push and pop when full is not accepted, because upd_ready is already 0.
  - Simultaneous push and pop at any other occupancy leaves count unchanged.
- ram_* outputs are combinational from state and arbitration; ram_en=0 when the port is idle.

Decomposition:
- Shared package: state enum (INIT, RUN), counter constants (SNT=00, WNT=01, WT=10, ST=11), and a saturating-update function.
- One natural sub-module, pht_upd_fifo: parameterised Q_DEPTH×(IDX_W+1) FIFO with push/pop/full/empty/count.

Test Plan:
- Reset, then idle → init_busy=1 for 256 cycles; ram_addr 0..255 each written with 01; init_busy=0 at cycle 256; lookups stalled before that.
- After init, lookup pc=0x40 → ram_addr=0x10 at t, predict_valid=1 and predict_taken=0 at t+1.
- Three taken updates to pc=0x40, no lookups → counter 01→10→11→11 (saturates); subsequent lookup gives predict_taken=1. Four not-taken updates → counter reaches 00 and holds.
- Update queued, lookup_valid held high continuously → update stalled for exactly 8 cycles; port forced on the 9th with lookup_stall=1; RMW then completes.
- Pending write to index 0x10 (value 10) deferred by a lookup to pc=0x40 → predict_taken=1 via forwarding, not the stale RAM 01.
- Push 4 updates while lookups hog the port → upd_ready=0 at count 4. Assert reset_n low mid-RMW → queue empty, pending write dropped, init restarts from address 0.

Source files
------------

// File: rtl/pht_access_ctrl_pkg.sv
// Shared types and helpers for the PHT access controller: FSM states,
// 2-bit counter encodings and the saturating counter update.
package pht_access_ctrl_pkg;

    typedef enum logic {
        ST_INIT = 1'b0,
        ST_RUN  = 1'b1
    } state_t;

    localparam logic [1:0] SNT = 2'b00;
    localparam logic [1:0] WNT = 2'b01;
    localparam logic [1:0] WT  = 2'b10;
    localparam logic [1:0] ST  = 2'b11;

    function automatic logic [1:0] sat_update(input logic [1:0] ctr, input logic taken);
        if (taken) return (ctr == ST)  ? ST  : ctr + 2'd1;
        else       return (ctr == SNT) ? SNT : ctr - 2'd1;
    endfunction

endpackage

// File: rtl/pht_upd_fifo.sv
// Resolved-branch update queue: power-of-two FIFO with wrap-around pointers
// and an occupancy count. Pushes when full and pops when empty are ignored.
module pht_upd_fifo #(
    parameter  int DEPTH = 4,
    parameter  int W     = 9,
    localparam int PTR_W = $clog2(DEPTH),
    localparam int CNT_W = $clog2(DEPTH) + 1
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             push,
    input  logic [W-1:0]     push_data,
    input  logic             pop,
    output logic [W-1:0]     head,
    output logic             full,
    output logic             empty,
    output logic [CNT_W-1:0] count
);

    logic [W-1:0]     mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic             push_ok;
    logic             pop_ok;

    assign full    = (count == CNT_W'(DEPTH));
    assign empty   = (count == '0);
    assign push_ok = push && !full;
    assign pop_ok  = pop && !empty;
    assign head    = mem[rd_ptr];

    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples pre-edge values regardless of statement order.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push_ok) wr_ptr <= wr_ptr + PTR_W'(1);
            if (pop_ok)  rd_ptr <= rd_ptr + PTR_W'(1);
            case ({push_ok, pop_ok})
                2'b10:   count <= count + CNT_W'(1);
                2'b01:   count <= count - CNT_W'(1);
                default: count <= count;
            endcase
        end
    end

    // NOTE: storage is deliberately not reset; pointers and count define
    // which entries are live, so the array maps onto plain RAM/flops.
    always_ff @(posedge clk) begin
        if (push_ok) mem[wr_ptr] <= push_data;
    end

endmodule

// File: rtl/pht_access_ctrl.sv
// PHT port controller: initialises the counter table after reset, then shares
// the single RAM port between IF lookups and queued read-modify-write updates.
module pht_access_ctrl
    import pht_access_ctrl_pkg::*;
#(
    parameter int         IDX_W      = 8,
    parameter int         Q_DEPTH    = 4,
    parameter logic [1:0] INIT_VAL   = 2'b01,
    parameter int         STARVE_LIM = 8
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             lookup_valid,
    input  logic [31:0]      lookup_pc,
    output logic             lookup_stall,
    output logic             predict_valid,
    output logic             predict_taken,
    input  logic             upd_valid,
    input  logic [31:0]      upd_pc,
    input  logic             upd_taken,
    output logic             upd_ready,
    output logic             init_busy,
    output logic             ram_en,
    output logic             ram_we,
    output logic [IDX_W-1:0] ram_addr,
    output logic [1:0]       ram_wdata,
    input  logic [1:0]       ram_rdata
);

    localparam int SC_W  = $clog2(STARVE_LIM + 1);
    localparam int CNT_W = $clog2(Q_DEPTH) + 1;

    state_t             state;
    state_t             state_nxt;
    logic [IDX_W-1:0]   init_addr;
    logic [SC_W-1:0]    starve_cnt;

    logic               pend_valid;
    logic [IDX_W-1:0]   pend_idx;
    logic [1:0]         pend_val;
    logic               rd_inflight;
    logic [IDX_W-1:0]   rd_idx;
    logic               rd_taken;

    logic               pred_vld_q;
    logic               fwd_hit_q;
    logic               fwd_taken_q;

    logic               fifo_push;
    logic               fifo_pop;
    logic [IDX_W:0]     fifo_head;
    logic               fifo_full;
    logic               fifo_empty;
    logic [CNT_W-1:0]   fifo_count;

    logic [IDX_W-1:0]   lookup_idx;
    logic               has_work;
    logic               force_upd;
    logic               lookup_gnt;
    logic               eng_gnt;

    assign lookup_idx = lookup_pc[IDX_W+1:2];

    // While a read is in flight the popped entry is not yet pending, so the
    // engine must not pop again; that keeps same-index updates in order.
    assign has_work  = pend_valid || (!rd_inflight && !fifo_empty);
    assign force_upd = has_work && (starve_cnt == SC_W'(STARVE_LIM));
    assign fifo_pop  = eng_gnt && !pend_valid;

    assign init_busy = (state == ST_INIT);
    assign upd_ready = !init_busy && !fifo_full;
    assign fifo_push = upd_valid && upd_ready;

    assign predict_valid = pred_vld_q;
    assign predict_taken = pred_vld_q && (fwd_hit_q ? fwd_taken_q : ram_rdata[1]);

    pht_upd_fifo #(
        .DEPTH (Q_DEPTH),
        .W     (IDX_W + 1)
    ) u_fifo (
        .clk       (clk),
        .reset_n   (reset_n),
        .push      (fifo_push),
        .push_data ({upd_pc[IDX_W+1:2], upd_taken}),
        .pop       (fifo_pop),
        .head      (fifo_head),
        .full      (fifo_full),
        .empty     (fifo_empty),
        .count     (fifo_count)
    );

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state     <= ST_INIT;
            init_addr <= '0;
        end else begin
            state <= state_nxt;
            if (state == ST_INIT) init_addr <= init_addr + IDX_W'(1);
        end
    end

    always_comb begin
        state_nxt = state;
        if (state == ST_INIT && init_addr == '1) state_nxt = ST_RUN;
    end

    always_comb begin
        // NOTE: every output of this block gets a default first so no path
        // through the branches can infer a latch.
        lookup_gnt   = 1'b0;
        eng_gnt      = 1'b0;
        lookup_stall = 1'b0;
        ram_en       = 1'b0;
        ram_we       = 1'b0;
        ram_addr     = '0;
        ram_wdata    = '0;
        if (state == ST_INIT) begin
            // Port stays quiet while reset is held; writes start on release.
            lookup_stall = 1'b1;
            ram_en       = reset_n;
            ram_we       = 1'b1;
            ram_addr     = init_addr;
            ram_wdata    = INIT_VAL;
        end else begin
            if (force_upd) begin
                eng_gnt      = 1'b1;
                lookup_stall = lookup_valid;
            end else if (lookup_valid) begin
                lookup_gnt = 1'b1;
            end else if (has_work) begin
                eng_gnt = 1'b1;
            end

            if (lookup_gnt) begin
                ram_en   = 1'b1;
                ram_addr = lookup_idx;
            end else if (eng_gnt) begin
                ram_en = 1'b1;
                if (pend_valid) begin
                    ram_we    = 1'b1;
                    ram_addr  = pend_idx;
                    ram_wdata = pend_val;
                end else begin
                    ram_addr = fifo_head[IDX_W:1];
                end
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            starve_cnt  <= '0;
            pend_valid  <= 1'b0;
            pend_idx    <= '0;
            pend_val    <= '0;
            rd_inflight <= 1'b0;
            rd_idx      <= '0;
            rd_taken    <= 1'b0;
        end else begin
            if (eng_gnt)
                starve_cnt <= '0;
            else if (has_work && lookup_gnt && starve_cnt != SC_W'(STARVE_LIM))
                starve_cnt <= starve_cnt + SC_W'(1);

            rd_inflight <= fifo_pop;
            if (fifo_pop) begin
                rd_idx   <= fifo_head[IDX_W:1];
                rd_taken <= fifo_head[0];
            end

            if (rd_inflight) begin
                pend_valid <= 1'b1;
                pend_idx   <= rd_idx;
                pend_val   <= sat_update(ram_rdata, rd_taken);
            end else if (eng_gnt && pend_valid) begin
                pend_valid <= 1'b0;
            end
        end
    end

    // A deferred write is newer than the RAM copy, so a lookup of the same
    // index takes its direction from the pending value.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            pred_vld_q  <= 1'b0;
            fwd_hit_q   <= 1'b0;
            fwd_taken_q <= 1'b0;
        end else begin
            pred_vld_q  <= lookup_gnt;
            fwd_hit_q   <= lookup_gnt && pend_valid && (pend_idx == lookup_idx);
            fwd_taken_q <= pend_val[1];
        end
    end

    logic unused_bits;
    assign unused_bits = ^{lookup_pc[31:IDX_W+2], lookup_pc[1:0],
                           upd_pc[31:IDX_W+2], upd_pc[1:0], fifo_count};

endmodule

// File: tb/tb_pht_access_ctrl.sv
// Bench for pht_access_ctrl: directed scenarios plus a randomized phase,
// with an external RAM model and a counter-table reference model.
module tb_pht_access_ctrl;

    localparam int DEPTH = 256;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic        lookup_valid = 1'b0;
    logic [31:0] lookup_pc = '0;
    logic        lookup_stall;
    logic        predict_valid;
    logic        predict_taken;
    logic        upd_valid = 1'b0;
    logic [31:0] upd_pc = '0;
    logic        upd_taken = 1'b0;
    logic        upd_ready;
    logic        init_busy;
    logic        ram_en;
    logic        ram_we;
    logic [7:0]  ram_addr;
    logic [1:0]  ram_wdata;
    logic [1:0]  ram_rdata = '0;

    logic [1:0]  mem     [DEPTH];
    logic [1:0]  ref_tbl [DEPTH];

    int passed = 0;
    int total  = 0;

    always #5 clk = ~clk;

    pht_access_ctrl #(
        .IDX_W      (8),
        .Q_DEPTH    (4),
        .INIT_VAL   (2'b01),
        .STARVE_LIM (8)
    ) dut (
        .clk           (clk),
        .reset_n       (reset_n),
        .lookup_valid  (lookup_valid),
        .lookup_pc     (lookup_pc),
        .lookup_stall  (lookup_stall),
        .predict_valid (predict_valid),
        .predict_taken (predict_taken),
        .upd_valid     (upd_valid),
        .upd_pc        (upd_pc),
        .upd_taken     (upd_taken),
        .upd_ready     (upd_ready),
        .init_busy     (init_busy),
        .ram_en        (ram_en),
        .ram_we        (ram_we),
        .ram_addr      (ram_addr),
        .ram_wdata     (ram_wdata),
        .ram_rdata     (ram_rdata)
    );

    // Single-port synchronous-read RAM macro.
    always @(posedge clk) begin
        if (ram_en) begin
            if (ram_we) mem[ram_addr] <= ram_wdata;
            else        ram_rdata     <= mem[ram_addr];
        end
    end

    function automatic logic [1:0] ref_next(input logic [1:0] c, input logic taken);
        int v;
        v = int'(c) + (taken ? 1 : -1);
        if (v > 3) v = 3;
        if (v < 0) v = 0;
        return 2'(v);
    endfunction

    task automatic ref_reset();
        for (int i = 0; i < DEPTH; i++) ref_tbl[i] = 2'b01;
    endtask

    task automatic drain(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic check_mem(input logic [7:0] idx, input logic [1:0] exp, input string name);
        total++;
        if (mem[idx] !== exp)
            $display("FAIL %s: table[%0h]=%b, required %b", name, idx, mem[idx], exp);
        else passed++;
    endtask

    task automatic do_update(input logic [31:0] pc, input logic taken);
        int k;
        @(negedge clk);
        upd_valid = 1'b1; upd_pc = pc; upd_taken = taken;
        #1;
        for (k = 0; k < 40 && !upd_ready; k++) begin @(negedge clk); #1; end
        total++;
        if (!upd_ready) $display("FAIL push_accept: upd_ready=0 after %0d cycles, required 1", k);
        else begin
            passed++;
            ref_tbl[pc[9:2]] = ref_next(ref_tbl[pc[9:2]], taken);
        end
        @(negedge clk);
        upd_valid = 1'b0;
    endtask

    task automatic lookup_check(input logic [31:0] pc, input logic exp_taken, input string name);
        int k;
        @(negedge clk);
        lookup_valid = 1'b1; lookup_pc = pc;
        #1;
        for (k = 0; k < 20 && lookup_stall; k++) begin @(negedge clk); #1; end
        @(negedge clk);
        lookup_valid = 1'b0;
        #1;
        total++;
        if ({predict_valid, predict_taken} !== {1'b1, exp_taken})
            $display("FAIL %s: valid,taken=%b%b, required 1%b", name, predict_valid, predict_taken, exp_taken);
        else passed++;
    endtask

    // Starts right after reset release; checks one init write per cycle.
    task automatic init_check(input string name);
        logic [13:0] got;
        logic [13:0] exp;
        for (int i = 0; i < DEPTH; i++) begin
            lookup_valid = 1'b1;
            lookup_pc    = $urandom;
            #1;
            got = {ram_en, ram_we, ram_addr, ram_wdata, init_busy, lookup_stall, upd_ready};
            exp = {1'b1, 1'b1, 8'(i), 2'b01, 1'b1, 1'b1, 1'b0};
            total++;
            if (got !== exp) $display("FAIL %s[%0d]: outputs=%b, required %b", name, i, got, exp);
            else passed++;
            @(negedge clk);
        end
        lookup_valid = 1'b0;
        #1;
        total++;
        if ({init_busy, upd_ready} !== 2'b01)
            $display("FAIL %s_done: init_busy,upd_ready=%b, required 01", name, {init_busy, upd_ready});
        else passed++;
    endtask

    task automatic test_reset();
        reset_n = 1'b0; lookup_valid = 1'b1; lookup_pc = 32'h40; upd_valid = 1'b1;
        repeat (3) @(negedge clk);
        #1;
        total++;
        if ({predict_valid, predict_taken, lookup_stall, upd_ready, init_busy, ram_en} !== 6'b001010)
            $display("FAIL reset_outputs: got %b, required 001010",
                     {predict_valid, predict_taken, lookup_stall, upd_ready, init_busy, ram_en});
        else passed++;
        lookup_valid = 1'b0; upd_valid = 1'b0;
        @(negedge clk);
        reset_n = 1'b1;
    endtask

    task automatic test_init();
        int bad;
        init_check("init_seq");
        bad = 0;
        for (int i = 0; i < DEPTH; i++) if (mem[i] !== 2'b01) bad++;
        total++;
        if (bad != 0) $display("FAIL init_contents: %0d entries not 01, required 0", bad);
        else passed++;
        ref_reset();
    endtask

    task automatic test_lookup_basic();
        @(negedge clk);
        lookup_valid = 1'b1; lookup_pc = 32'h40;
        #1;
        total++;
        if ({ram_en, ram_we, ram_addr, lookup_stall} !== {1'b1, 1'b0, 8'h10, 1'b0})
            $display("FAIL lookup_grant: en,we,addr,stall=%b,%b,%h,%b, required 1,0,10,0",
                     ram_en, ram_we, ram_addr, lookup_stall);
        else passed++;
        @(negedge clk);
        lookup_valid = 1'b0;
        #1;
        total++;
        if ({predict_valid, predict_taken} !== 2'b10)
            $display("FAIL lookup_predict: valid,taken=%b%b, required 10", predict_valid, predict_taken);
        else passed++;
        @(negedge clk);
        #1;
        total++;
        if (predict_valid !== 1'b0) $display("FAIL lookup_idle: predict_valid=%b, required 0", predict_valid);
        else passed++;
    endtask

    task automatic test_saturate();
        for (int i = 0; i < 3; i++) begin
            do_update(32'h40, 1'b1);
            drain(6);
            check_mem(8'h10, ref_tbl[8'h10], "sat_taken");
        end
        lookup_check(32'h40, ref_tbl[8'h10][1], "sat_taken_predict");
        for (int i = 0; i < 4; i++) begin
            do_update(32'h40, 1'b0);
            drain(6);
            check_mem(8'h10, ref_tbl[8'h10], "sat_not_taken");
        end
        lookup_check(32'h40, ref_tbl[8'h10][1], "sat_not_taken_predict");
    endtask

    task automatic test_back_to_back();
        @(negedge clk);
        upd_valid = 1'b1; upd_pc = 32'hC0; upd_taken = 1'b1;
        for (int i = 0; i < 2; i++) begin
            #1;
            total++;
            if (upd_ready !== 1'b1) $display("FAIL b2b_accept: upd_ready=%b, required 1", upd_ready);
            else begin
                passed++;
                ref_tbl[8'h30] = ref_next(ref_tbl[8'h30], 1'b1);
            end
            @(negedge clk);
        end
        upd_valid = 1'b0;
        drain(10);
        check_mem(8'h30, ref_tbl[8'h30], "b2b_same_index");
    endtask

    task automatic test_starvation();
        int k;
        @(negedge clk);
        lookup_valid = 1'b1; lookup_pc = 32'h200;
        upd_valid = 1'b1; upd_pc = 32'h80; upd_taken = 1'b1;
        #1;
        total++;
        if (upd_ready !== 1'b1) $display("FAIL starve_push: upd_ready=%b, required 1", upd_ready);
        else begin passed++; ref_tbl[8'h20] = ref_next(ref_tbl[8'h20], 1'b1); end
        @(negedge clk);
        upd_valid = 1'b0;
        for (k = 0; k < 20; k++) begin #1; if (lookup_stall) break; @(negedge clk); end
        total++;
        if (k != 8) $display("FAIL starve_read_delay: %0d cycles, required 8", k);
        else passed++;
        total++;
        if ({ram_en, ram_we, ram_addr} !== {1'b1, 1'b0, 8'h20})
            $display("FAIL starve_read: en,we,addr=%b,%b,%h, required 1,0,20", ram_en, ram_we, ram_addr);
        else passed++;
        @(negedge clk);
        #1;
        total++;
        if ({predict_valid, lookup_stall} !== 2'b00)
            $display("FAIL starve_after_force: valid,stall=%b%b, required 00", predict_valid, lookup_stall);
        else passed++;
        @(negedge clk);
        for (k = 0; k < 20; k++) begin #1; if (lookup_stall) break; @(negedge clk); end
        total++;
        if (k != 8) $display("FAIL starve_write_delay: %0d cycles, required 8", k);
        else passed++;
        total++;
        if ({ram_en, ram_we, ram_addr, ram_wdata} !== {1'b1, 1'b1, 8'h20, ref_tbl[8'h20]})
            $display("FAIL starve_write: en,we,addr,wdata=%b,%b,%h,%b, required 1,1,20,%b",
                     ram_en, ram_we, ram_addr, ram_wdata, ref_tbl[8'h20]);
        else passed++;
        @(negedge clk);
        lookup_valid = 1'b0;
        drain(6);
        check_mem(8'h20, ref_tbl[8'h20], "starve_result");
    endtask

    task automatic test_forwarding();
        int k;
        do_update(32'h40, 1'b1);
        drain(6);
        check_mem(8'h10, 2'b01, "fwd_setup");
        @(negedge clk);
        lookup_valid = 1'b1; lookup_pc = 32'h100;
        upd_valid = 1'b1; upd_pc = 32'h40; upd_taken = 1'b1;
        #1;
        total++;
        if (upd_ready !== 1'b1) $display("FAIL fwd_push: upd_ready=%b, required 1", upd_ready);
        else begin passed++; ref_tbl[8'h10] = ref_next(ref_tbl[8'h10], 1'b1); end
        @(negedge clk);
        upd_valid = 1'b0;
        for (k = 0; k < 30; k++) begin
            #1;
            if (ram_en && !ram_we && ram_addr == 8'h10 && lookup_stall) break;
            @(negedge clk);
        end
        total++;
        if (k >= 30) $display("FAIL fwd_read_seen: engine read not observed, required within 30 cycles");
        else passed++;
        @(negedge clk);
        @(negedge clk);
        lookup_pc = 32'h40;
        #1;
        total++;
        if ({lookup_stall, ram_en, ram_we, ram_addr} !== {1'b0, 1'b1, 1'b0, 8'h10})
            $display("FAIL fwd_lookup_grant: stall,en,we,addr=%b,%b,%b,%h, required 0,1,0,10",
                     lookup_stall, ram_en, ram_we, ram_addr);
        else passed++;
        @(negedge clk);
        lookup_valid = 1'b0;
        #1;
        total++;
        if ({predict_valid, predict_taken} !== {1'b1, ref_tbl[8'h10][1]})
            $display("FAIL fwd_predict: valid,taken=%b%b, required 1%b",
                     predict_valid, predict_taken, ref_tbl[8'h10][1]);
        else passed++;
        check_mem(8'h10, 2'b01, "fwd_ram_still_old");
        drain(6);
        check_mem(8'h10, ref_tbl[8'h10], "fwd_result");
    endtask

    task automatic test_queue_full_reset();
        int k;
        int bad;
        @(negedge clk);
        lookup_valid = 1'b1; lookup_pc = 32'h100;
        for (int i = 0; i < 4; i++) begin
            upd_valid = 1'b1; upd_pc = 32'(8'h50 + i) << 2; upd_taken = 1'b1;
            #1;
            total++;
            if (upd_ready !== 1'b1) $display("FAIL qfull_push%0d: upd_ready=%b, required 1", i, upd_ready);
            else passed++;
            @(negedge clk);
        end
        upd_pc = 32'h200;
        #1;
        total++;
        if ({upd_ready, lookup_stall} !== 2'b00)
            $display("FAIL qfull_ready: upd_ready,stall=%b%b, required 00", upd_ready, lookup_stall);
        else passed++;
        upd_valid = 1'b0;
        @(negedge clk);
        for (k = 0; k < 20; k++) begin
            #1;
            if (ram_en && !ram_we && lookup_stall) break;
            @(negedge clk);
        end
        total++;
        if (k >= 20) $display("FAIL qfull_forced_read: not observed, required within 20 cycles");
        else passed++;
        @(negedge clk);
        #2;
        reset_n = 1'b0;
        #1;
        total++;
        if ({predict_valid, lookup_stall, upd_ready, init_busy, ram_en} !== 5'b01010)
            $display("FAIL midrmw_reset: valid,stall,ready,busy,en=%b, required 01010",
                     {predict_valid, lookup_stall, upd_ready, init_busy, ram_en});
        else passed++;
        lookup_valid = 1'b0;
        @(negedge clk);
        reset_n = 1'b1;
        ref_reset();
        init_check("reinit_seq");
        bad = 0;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            #1;
            if (ram_en !== 1'b0) bad++;
        end
        total++;
        if (bad != 0) $display("FAIL reinit_idle: ram_en high in %0d cycles, required 0", bad);
        else passed++;
    endtask

    task automatic test_random();
        logic prev_gnt;
        logic [31:0] pc;
        prev_gnt = 1'b0;
        for (int c = 0; c < 3000; c++) begin
            @(negedge clk);
            pc = $urandom; pc[9:2] = 8'($urandom_range(0, 15));
            lookup_pc    = pc;
            lookup_valid = ($urandom_range(0, 3) != 0);
            pc = $urandom; pc[9:2] = 8'($urandom_range(0, 15));
            upd_pc    = pc;
            upd_valid = ($urandom_range(0, 2) == 0);
            upd_taken = 1'($urandom);
            #1;
            total++;
            if (predict_valid !== prev_gnt)
                $display("FAIL rand_predict_valid@%0d: got %b, required %b", c, predict_valid, prev_gnt);
            else passed++;
            if (upd_valid && upd_ready)
                ref_tbl[upd_pc[9:2]] = ref_next(ref_tbl[upd_pc[9:2]], upd_taken);
            prev_gnt = lookup_valid && !lookup_stall;
        end
        @(negedge clk);
        lookup_valid = 1'b0; upd_valid = 1'b0;
        drain(40);
        for (int i = 0; i < DEPTH; i++) check_mem(8'(i), ref_tbl[i], "rand_table");
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: time limit reached before summary");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_init();
        test_lookup_basic();
        test_saturate();
        test_back_to_back();
        test_starvation();
        test_forwarding();
        test_queue_full_reset();
        test_random();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
